instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_pkg.sv | 84 ++++++++
 rtl/instr_word_fmt.sv | 60 ++++++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared operation enum, MIPS opcode/funct constants and
//               field-packing helpers for the instruction encoder and the
//               decoder testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

   // Request operation select; values 20..31 are illegal.
   typedef enum logic [4:0] {
      OP_NOP    = 5'd0,
      OP_ADDU   = 5'd1,
      OP_SUBU   = 5'd2,
      OP_AND    = 5'd3,
      OP_OR     = 5'd4,
      OP_SLTU   = 5'd5,
      OP_MULTU  = 5'd6,
      OP_MFHI   = 5'd7,
      OP_MFLO   = 5'd8,
      OP_JR     = 5'd9,
      OP_LW     = 5'd10,
      OP_SW     = 5'd11,
      OP_BEQ    = 5'd12,
      OP_ADDIU  = 5'd13,
      OP_ORI    = 5'd14,
      OP_LUI    = 5'd15,
      OP_BLTZAL = 5'd16,
      OP_J      = 5'd17,
      OP_JAL    = 5'd18,
      OP_LI32   = 5'd19
   } instr_op_e;

   // Primary opcodes
   localparam logic [5:0] c_opc_special = 6'b000000;
   localparam logic [5:0] c_opc_regimm  = 6'b000001;
   localparam logic [5:0] c_opc_j       = 6'b000010;
   localparam logic [5:0] c_opc_jal     = 6'b000011;
   localparam logic [5:0] c_opc_beq     = 6'b000100;
   localparam logic [5:0] c_opc_addiu   = 6'b001001;
   localparam logic [5:0] c_opc_ori     = 6'b001101;
   localparam logic [5:0] c_opc_lui     = 6'b001111;
   localparam logic [5:0] c_opc_lw      = 6'b100011;
   localparam logic [5:0] c_opc_sw      = 6'b101011;

   // SPECIAL-class function codes
   localparam logic [5:0] c_fn_jr       = 6'b001000;
   localparam logic [5:0] c_fn_mfhi     = 6'b010000;
   localparam logic [5:0] c_fn_mflo     = 6'b010010;
   localparam logic [5:0] c_fn_multu    = 6'b011001;
   localparam logic [5:0] c_fn_addu     = 6'b100001;
   localparam logic [5:0] c_fn_subu     = 6'b100011;
   localparam logic [5:0] c_fn_and      = 6'b100100;
   localparam logic [5:0] c_fn_or       = 6'b100101;
   localparam logic [5:0] c_fn_sltu     = 6'b101011;

   // REGIMM rt selector for BLTZAL
   localparam logic [4:0] c_rt_bltzal   = 5'b10000;

   // R-type word with shamt fixed at zero
   function automatic logic [31:0] fmt_r(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [5:0] fn);
      return {c_opc_special, rs, rt, rd, 5'b00000, fn};
   endfunction

   // I-type word
   function automatic logic [31:0] fmt_i(input logic [5:0]  opc,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [15:0] imm16);
      return {opc, rs, rt, imm16};
   endfunction

   // J-type word
   function automatic logic [31:0] fmt_j(input logic [5:0]  opc,
                                         input logic [25:0] target);
      return {opc, target};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_word_fmt.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_fmt
// Description : Pure combinational word formation. Maps an operation and its
//               fields to one or two 32-bit instruction words and flags
//               illegal operations.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_fmt
   import instr_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic [31:0] word2,
   output logic        pair,
   output logic        legal
);

   // Decode the operation; word2 is only meaningful for the LI32 expansion
   always_comb begin
      word  = '0;
      word2 = '0;
      pair  = 1'b0;
      legal = 1'b1;
      case (op)
         OP_NOP:    word = '0;
         OP_ADDU:   word = fmt_r(rs, rt, rd, c_fn_addu);
         OP_SUBU:   word = fmt_r(rs, rt, rd, c_fn_subu);
         OP_AND:    word = fmt_r(rs, rt, rd, c_fn_and);
         OP_OR:     word = fmt_r(rs, rt, rd, c_fn_or);
         OP_SLTU:   word = fmt_r(rs, rt, rd, c_fn_sltu);
         OP_MULTU:  word = fmt_r(rs, rt, 5'd0, c_fn_multu);
         OP_MFHI:   word = fmt_r(5'd0, 5'd0, rd, c_fn_mfhi);
         OP_MFLO:   word = fmt_r(5'd0, 5'd0, rd, c_fn_mflo);
         OP_JR:     word = fmt_r(rs, 5'd0, 5'd0, c_fn_jr);
         OP_LW:     word = fmt_i(c_opc_lw,    rs, rt, imm[15:0]);
         OP_SW:     word = fmt_i(c_opc_sw,    rs, rt, imm[15:0]);
         OP_BEQ:    word = fmt_i(c_opc_beq,   rs, rt, imm[15:0]);
         OP_ADDIU:  word = fmt_i(c_opc_addiu, rs, rt, imm[15:0]);
         OP_ORI:    word = fmt_i(c_opc_ori,   rs, rt, imm[15:0]);
         OP_LUI:    word = fmt_i(c_opc_lui,   5'd0, rt, imm[15:0]);
         OP_BLTZAL: word = fmt_i(c_opc_regimm, rs, c_rt_bltzal, imm[15:0]);
         OP_J:      word = fmt_j(c_opc_j,   imm[25:0]);
         OP_JAL:    word = fmt_j(c_opc_jal, imm[25:0]);
         OP_LI32: begin
            // LUI rt,hi followed by ORI rt,rt,lo
            word  = fmt_i(c_opc_lui, 5'd0, rt, imm[31:16]);
            word2 = fmt_i(c_opc_ori, rt,   rt, imm[15:0]);
            pair  = 1'b1;
         end
         default:   legal = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Registered instruction encoder with valid/ready handshakes,
//               LI32 pseudo-op expansion, emit-address counter and a sticky
//               illegal-operation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
   import instr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   input  logic        load_addr,
   input  logic [31:0] start_addr,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_FULL      = 2'd1,
      ST_FULL_PEND = 2'd2
   } state_e;

   state_e      r_state;
   logic        r_out_valid;
   logic [31:0] r_out_instr;
   logic [31:0] r_out_addr;
   logic [31:0] r_pend_word;
   logic        r_err;

   logic [31:0] w_word;
   logic [31:0] w_word2;
   logic        w_pair;
   logic        w_legal;
   logic        w_load;
   logic        w_accept;
   logic        w_drain;
   logic        w_unused;

   instr_word_fmt u_word_fmt (
      .op    (in_op),
      .rs    (in_rs),
      .rt    (in_rt),
      .rd    (in_rd),
      .imm   (in_imm),
      .word  (w_word),
      .word2 (w_word2),
      .pair  (w_pair),
      .legal (w_legal)
   );

   // A new request fits when the output register is free now or frees this cycle
   assign in_ready  = (r_state == ST_EMPTY) | ((r_state == ST_FULL) & out_ready);

   // An address load in EMPTY wins over a simultaneous request
   assign w_load    = load_addr & (r_state == ST_EMPTY);
   assign w_accept  = in_valid & in_ready & ~w_load;
   assign w_drain   = r_out_valid & out_ready;

   // The emit address is always word aligned; the low start bits are dropped
   assign w_unused  = ^start_addr[1:0];

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_addr  = r_out_addr;
   assign err       = r_err;

   // Handshake FSM, output register, pending LI32 half and address counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_addr  <= '0;
         r_pend_word <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load) begin
                  r_out_addr <= {start_addr[31:2], 2'b00};
               end else if (w_accept) begin
                  if (w_legal) begin
                     r_out_instr <= w_word;
                     r_pend_word <= w_word2;
                     r_out_valid <= 1'b1;
                     r_state     <= w_pair ? ST_FULL_PEND : ST_FULL;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            ST_FULL: begin
               // Acceptance here implies out_ready, so it always coincides with a drain
               if (w_drain) begin
                  r_out_addr <= r_out_addr + 32'd4;
                  if (w_accept && w_legal) begin
                     r_out_instr <= w_word;
                     r_pend_word <= w_word2;
                     r_out_valid <= 1'b1;
                     r_state     <= w_pair ? ST_FULL_PEND : ST_FULL;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_EMPTY;
                     if (w_accept) begin
                        r_err <= 1'b1;
                     end
                  end
               end
            end

            ST_FULL_PEND: begin
               // Second half of LI32 follows at the next address
               if (w_drain) begin
                  r_out_addr  <= r_out_addr + 32'd4;
                  r_out_instr <= r_pend_word;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_FULL;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. A queue-based model of
//               the emitted word stream is compared with the DUT every cycle;
//               directed sequences add literal checks on known encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
   import instr_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op, in_rs, in_rt, in_rd;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        load_addr;
   logic [31:0] start_addr;
   logic        err;

   int n_vec  = 0;
   int n_miss = 0;

   instr_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .load_addr  (load_addr),
      .start_addr (start_addr),
      .err        (err)
   );

   always #5 clk = ~clk;

   // One comparison: count it, report it if wrong
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] r_w(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input int fn);
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
   endfunction

   function automatic logic [31:0] i_w(input int opc, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [31:0] v);
      return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (v & 32'h0000FFFF);
   endfunction

   // Reference encoding: returns the number of words (0 = illegal op)
   function automatic int model_enc(input logic [4:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [31:0] imm,
                                    output logic [31:0] w0, output logic [31:0] w1);
      int n;
      w0 = 32'h0;
      w1 = 32'h0;
      n  = 1;
      case (op)
         OP_NOP:    w0 = 32'h0;
         OP_ADDU:   w0 = r_w(rs, rt, rd, 'h21);
         OP_SUBU:   w0 = r_w(rs, rt, rd, 'h23);
         OP_AND:    w0 = r_w(rs, rt, rd, 'h24);
         OP_OR:     w0 = r_w(rs, rt, rd, 'h25);
         OP_SLTU:   w0 = r_w(rs, rt, rd, 'h2B);
         OP_MULTU:  w0 = r_w(rs, rt, 5'd0, 'h19);
         OP_MFHI:   w0 = r_w(5'd0, 5'd0, rd, 'h10);
         OP_MFLO:   w0 = r_w(5'd0, 5'd0, rd, 'h12);
         OP_JR:     w0 = r_w(rs, 5'd0, 5'd0, 'h08);
         OP_LW:     w0 = i_w('h23, rs, rt, imm);
         OP_SW:     w0 = i_w('h2B, rs, rt, imm);
         OP_BEQ:    w0 = i_w('h04, rs, rt, imm);
         OP_ADDIU:  w0 = i_w('h09, rs, rt, imm);
         OP_ORI:    w0 = i_w('h0D, rs, rt, imm);
         OP_LUI:    w0 = i_w('h0F, 5'd0, rt, imm);
         OP_BLTZAL: w0 = i_w('h01, rs, 5'd16, imm);
         OP_J:      w0 = (32'h2 << 26) | (imm & 32'h03FFFFFF);
         OP_JAL:    w0 = (32'h3 << 26) | (imm & 32'h03FFFFFF);
         OP_LI32: begin
            w0 = i_w('h0F, 5'd0, rt, imm >> 16);
            w1 = i_w('h0D, rt, rt, imm);
            n  = 2;
         end
         default:   n = 0;
      endcase
      return n;
   endfunction

   // Model state: words still to be emitted, next/current address, sticky error
   logic [31:0] m_q[$];
   logic [31:0] m_addr = 32'h0;
   logic        m_err  = 1'b0;
   bit          m_acc  = 1'b0;
   bit          m_live = 1'b0;

   // Advance the model on each rising edge from the bench's own inputs
   always @(posedge clk) begin : p_model
      logic [31:0] w0, w1;
      int  n;
      bit  rdy, drn, ld;
      m_live = 1'b1;
      m_acc  = 1'b0;
      if (reset) begin
         m_q.delete();
         m_addr = 32'h0;
         m_err  = 1'b0;
      end else begin
         rdy   = (m_q.size() == 0) || (m_q.size() == 1 && out_ready);
         drn   = (m_q.size() != 0) && out_ready;
         ld    = load_addr && (m_q.size() == 0);
         m_acc = in_valid && rdy && !ld;
         if (drn) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
         end
         if (ld)
            m_addr = start_addr & 32'hFFFFFFFC;
         if (m_acc) begin
            n = model_enc(in_op, in_rs, in_rt, in_rd, in_imm, w0, w1);
            if (n == 0) m_err = 1'b1;
            if (n >= 1) m_q.push_back(w0);
            if (n == 2) m_q.push_back(w1);
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin : p_compare
      bit exp_rdy;
      if (m_live) begin
         exp_rdy = (m_q.size() == 0) || (m_q.size() == 1 && out_ready);
         check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         check("in_ready",  32'(in_ready),  32'(exp_rdy));
         check("out_addr",  out_addr, m_addr);
         check("err",       32'(err), 32'(m_err));
         if (m_q.size() != 0)
            check("out_instr", out_instr, m_q[0]);
      end
   end

   // Present a request and hold it until the model says it was accepted
   task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (m_acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      n_vec++; n_miss++;
      $display("FAIL send_timeout: op %0d never accepted, expected acceptance within 20 cycles", op);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 20; i++) begin
         if (m_q.size() == 0) return;
         @(posedge clk); #1;
      end
      n_vec++; n_miss++;
      $display("FAIL drain_timeout: %0d words still held, expected 0", m_q.size());
   endtask

   logic [31:0] a0, p0, p1;

   initial begin : p_main
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
      in_imm = '0; out_ready = 1'b1; load_addr = 1'b0; start_addr = '0;

      // Pin the reference encoder against hand-computed words
      void'(model_enc(OP_ADDU, 5'd1, 5'd2, 5'd3, 32'h0, p0, p1));
      check("model_addu", p0, 32'h00221821);
      void'(model_enc(OP_LI32, 5'd0, 5'd8, 5'd0, 32'h12345678, p0, p1));
      check("model_li32_hi", p0, 32'h3C081234);
      check("model_li32_lo", p1, 32'h35085678);
      void'(model_enc(OP_JAL, 5'd0, 5'd0, 5'd0, 32'h00100010, p0, p1));
      check("model_jal", p0, 32'h0C100010);
      void'(model_enc(OP_ORI, 5'd0, 5'd4, 5'd0, 32'h000000FF, p0, p1));
      check("model_ori", p0, 32'h340400FF);

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_addr",  out_addr, 32'h0);
      check("rst_err",       32'(err), 32'h0);
      check("rst_in_ready",  32'(in_ready), 32'h1);

      // Basic R-type, latency one
      send(OP_ADDU, 5'd1, 5'd2, 5'd3, 32'h0);
      check("addu_word", out_instr, 32'h00221821);
      check("addu_addr", out_addr, 32'h00000000);

      // Back-to-back stream of every single-word op, unused fields set nonzero
      send(OP_SUBU,   5'd4,  5'd5,  5'd6,  32'h0);
      send(OP_AND,    5'd7,  5'd8,  5'd9,  32'h0);
      send(OP_OR,     5'd31, 5'd30, 5'd29, 32'h0);
      send(OP_SLTU,   5'd10, 5'd11, 5'd12, 32'h0);
      send(OP_MULTU,  5'd13, 5'd14, 5'd15, 32'h0);
      check("multu_rd0", out_instr, 32'h01AE0019);
      send(OP_MFHI,   5'd16, 5'd17, 5'd18, 32'h0);
      send(OP_MFLO,   5'd19, 5'd20, 5'd21, 32'h0);
      send(OP_JR,     5'd22, 5'd23, 5'd24, 32'h0);
      check("jr_rtrd0", out_instr, 32'h02C00008);
      send(OP_LW,     5'd1,  5'd2,  5'd3,  32'hABCD8004);
      send(OP_SW,     5'd3,  5'd4,  5'd5,  32'h0000FFFC);
      send(OP_BEQ,    5'd6,  5'd7,  5'd8,  32'hFFFF0010);
      send(OP_ADDIU,  5'd29, 5'd29, 5'd1,  32'h0000FFF0);
      send(OP_LUI,    5'd9,  5'd10, 5'd11, 32'h00001234);
      send(OP_BLTZAL, 5'd12, 5'd3,  5'd4,  32'h00000020);
      check("bltzal_word", out_instr, 32'h05900020);
      send(OP_J,      5'd1,  5'd1,  5'd1,  32'hFC000400);
      send(OP_NOP,    5'd5,  5'd6,  5'd7,  32'hFFFFFFFF);
      check("nop_word", out_instr, 32'h00000000);
      wait_empty();

      // LI32 expansion with the pending half blocking new requests
      send(OP_LI32, 5'd0, 5'd8, 5'd0, 32'h12345678);
      a0 = m_addr;
      check("li32_hi", out_instr, 32'h3C081234);
      check("li32_pend_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      check("li32_lo", out_instr, 32'h35085678);
      check("li32_lo_addr", out_addr, a0 + 32'd4);
      wait_empty();

      // LI32 stalled in its pending state, then a request racing the release
      out_ready = 1'b0;
      send(OP_LI32, 5'd0, 5'd2, 5'd0, 32'hCAFE0001);
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b1;
      send(OP_ADDU, 5'd2, 5'd2, 5'd2, 32'h0);
      wait_empty();

      // Output stall: JAL held stable, single drain on release
      out_ready = 1'b0;
      send(OP_JAL, 5'd0, 5'd0, 5'd0, 32'h00100010);
      a0 = out_addr;
      for (int i = 0; i < 3; i++) begin
         check("jal_hold_word", out_instr, 32'h0C100010);
         check("jal_hold_ready", 32'(in_ready), 32'h0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("jal_single_drain", 32'(out_valid), 32'h0);
      check("jal_addr_step", out_addr, a0 + 32'd4);

      // A second request waits while the first is stalled
      out_ready = 1'b0;
      send(OP_OR, 5'd1, 5'd2, 5'd3, 32'h0);
      fork
         send(OP_SUBU, 5'd3, 5'd2, 5'd1, 32'h0);
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_empty();

      // load_addr ignored while a word is held
      out_ready = 1'b0;
      send(OP_AND, 5'd1, 5'd1, 5'd1, 32'h0);
      a0 = out_addr;
      load_addr = 1'b1; start_addr = 32'h00000100;
      @(posedge clk); #1;
      load_addr = 1'b0;
      check("load_ignored", out_addr, a0);
      out_ready = 1'b1;
      wait_empty();

      // load_addr beats a simultaneous request in EMPTY
      load_addr = 1'b1; start_addr = 32'h00000043;
      in_op = OP_ADDU; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      load_addr = 1'b0; in_valid = 1'b0;
      check("load_prio_valid", 32'(out_valid), 32'h0);
      check("load_prio_addr", out_addr, 32'h00000040);

      // Address wrap
      load_addr = 1'b1; start_addr = 32'hFFFFFFFE;
      @(posedge clk); #1;
      load_addr = 1'b0;
      send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0);
      check("wrap_addr0", out_addr, 32'hFFFFFFFC);
      send(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0);
      check("wrap_addr1", out_addr, 32'h00000000);
      wait_empty();

      // Illegal op consumed silently, sets sticky err
      a0 = out_addr;
      send(5'd25, 5'd1, 5'd2, 5'd3, 32'h0);
      check("illegal_err", 32'(err), 32'h1);
      check("illegal_no_word", 32'(out_valid), 32'h0);
      check("illegal_addr", out_addr, a0);
      send(OP_ORI, 5'd0, 5'd4, 5'd0, 32'h000000FF);
      check("ori_word", out_instr, 32'h340400FF);
      check("ori_addr", out_addr, a0);
      send(5'd31, 5'd0, 5'd0, 5'd0, 32'h0);
      send(OP_MFHI, 5'd0, 5'd0, 5'd9, 32'h0);
      wait_empty();

      // Reset while the LI32 second half is pending
      out_ready = 1'b0;
      send(OP_LI32, 5'd0, 5'd9, 5'd0, 32'hDEADBEEF);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_addr",  out_addr, 32'h0);
      check("midrst_err",   32'(err), 32'h0);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready", 32'(in_ready), 32'h1);
      check("midrst_no_ori", 32'(out_valid), 32'h0);
      repeat (5) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
